seq_cla_subtractor: RTL and testbench

SEQ_CLA_SUBTRACTOR -- requirements
Module: seq_cla_subtractor

---
 rtl/seq_cla_subtractor.sv | 137 +++++++++++++
 tb/tb_seq_cla_subtractor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_cla_subtractor.sv
// Multi-cycle subtractor: computes iA - iB one ADDER_WIDTH slice per clock
// through a carry-lookahead slice, then reports borrow, signed overflow and zero.
module seq_cla_subtractor #(
  parameter int ADDER_WIDTH   = 8,
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iStart,
  input  logic [OPERAND_WIDTH-1:0] iA,
  input  logic [OPERAND_WIDTH-1:0] iB,
  output logic [OPERAND_WIDTH-1:0] oDiff,
  output logic                     oBorrow,
  output logic                     oOverflow,
  output logic                     oZero,
  output logic                     oBusy,
  output logic                     oDone
);

  localparam int NUM_SLICES = OPERAND_WIDTH / ADDER_WIDTH;
  localparam int IDX_W      = $clog2(NUM_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   accept;

  logic [NUM_SLICES-1:0][ADDER_WIDTH-1:0] a_q, b_q, diff_q, diff_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               borrow_q, overflow_q, zero_q, done_q;

  logic [ADDER_WIDTH-1:0] slice_a, slice_b, gen, prop, slice_sum;
  logic [ADDER_WIDTH:0]   carry;
  logic                   last_slice;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (iStart) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge iClk) begin
    if (iRst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Subtraction as A + ~B + carry; the carry register starts at 1 for the +1.
  always_comb begin
    slice_a  = a_q[idx_q];
    slice_b  = ~b_q[idx_q];
    gen      = slice_a & slice_b;
    prop     = slice_a ^ slice_b;
    carry    = '0;
    carry[0] = carry_q;
    for (int i = 0; i < ADDER_WIDTH; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
    slice_sum      = prop ^ carry[ADDER_WIDTH-1:0];
    diff_d         = diff_q;
    diff_d[idx_q]  = slice_sum;
    last_slice     = (idx_q == LAST_IDX);
  end

  // NOTE: the operand and result registers are plain flops rather than a
  // memory, so they take the reset like any other state.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      a_q        <= '0;
      b_q        <= '0;
      diff_q     <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b1;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_q     <= iA;
        b_q     <= iB;
        idx_q   <= '0;
        carry_q <= 1'b1;
      end else if (state_q == RUN) begin
        diff_q  <= diff_d;
        carry_q <= carry[ADDER_WIDTH];
        idx_q   <= idx_q + 1'b1;
        if (last_slice) begin
          borrow_q   <= ~carry[ADDER_WIDTH];
          overflow_q <= (a_q[NUM_SLICES-1][ADDER_WIDTH-1] != b_q[NUM_SLICES-1][ADDER_WIDTH-1]) &&
                        (slice_sum[ADDER_WIDTH-1] != a_q[NUM_SLICES-1][ADDER_WIDTH-1]);
          zero_q     <= (diff_d == '0);
          done_q     <= 1'b1;
          idx_q      <= '0;
          carry_q    <= 1'b1;
        end
      end
    end
  end

  assign oDiff     = diff_q;
  assign oBorrow   = borrow_q;
  assign oOverflow = overflow_q;
  assign oZero     = zero_q;
  assign oBusy     = (state_q == RUN);
  assign oDone     = done_q;

endmodule

// File: tb/tb_seq_cla_subtractor.sv
// Scoreboard bench for seq_cla_subtractor: expected results come from plain
// 32-bit arithmetic and are compared whenever the DUT pulses oDone.
module tb_seq_cla_subtractor;

  localparam int AW = 8;
  localparam int OW = 32;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iStart;
  logic [OW-1:0] iA, iB;
  logic [OW-1:0] oDiff;
  logic          oBorrow, oOverflow, oZero, oBusy, oDone;

  typedef struct packed {
    logic [OW-1:0] diff;
    logic          borrow;
    logic          ovf;
    logic          zero;
  } res_t;

  res_t sb_q[$];
  res_t last_exp;
  int   checks = 0;
  int   passes = 0;

  seq_cla_subtractor #(.ADDER_WIDTH(AW), .OPERAND_WIDTH(OW)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iStart    (iStart),
    .iA        (iA),
    .iB        (iB),
    .oDiff     (oDiff),
    .oBorrow   (oBorrow),
    .oOverflow (oOverflow),
    .oZero     (oZero),
    .oBusy     (oBusy),
    .oDone     (oDone)
  );

  always #5 iClk = ~iClk;

  function automatic res_t model(logic [OW-1:0] a, logic [OW-1:0] b);
    res_t   r;
    longint sd;
    r.diff   = a - b;
    r.borrow = (a < b);
    sd       = longint'($signed(a)) - longint'($signed(b));
    r.ovf    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    r.zero   = (r.diff == '0);
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops one expectation per oDone pulse.
  initial begin
    res_t e;
    forever begin
      @(negedge iClk);
      if (oDone === 1'b1) begin
        check("done_has_expectation", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("result", 64'({oDiff, oBorrow, oOverflow, oZero}), 64'(e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_op(logic [OW-1:0] a, logic [OW-1:0] b);
    iA       = a;
    iB       = b;
    iStart   = 1'b1;
    last_exp = model(a, b);
    sb_q.push_back(last_exp);
    @(posedge iClk); #1;
    iStart = 1'b0;
    iA     = $urandom;
    iB     = $urandom;
  endtask

  // Called right after the accepting edge; returns at the cycle oDone is high.
  task automatic wait_done(string tag, bit inject);
    int  lat  = -1;
    int  busy = 0;
    for (int k = 0; k <= 20; k++) begin
      busy += int'(oBusy);
      if (oDone === 1'b1) begin
        lat = k;
        break;
      end
      if (inject && k == 1) begin
        iStart = 1'b1;
        iA     = $urandom;
        iB     = $urandom;
      end
      if (inject && k == 2) iStart = 1'b0;
      @(posedge iClk); #1;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_busy_cycles"}, 64'(busy), 64'd4);
  endtask

  task automatic check_idle_outputs(string tag, res_t e);
    check({tag, "_held"}, 64'({oDiff, oBorrow, oOverflow, oZero, oBusy, oDone}),
          64'({e, 1'b0, 1'b0}));
  endtask

  logic [OW-1:0] dir_a [4] = '{32'h0000_0005, 32'h0000_0000, 32'h8000_0000, 32'h1234_5678};
  logic [OW-1:0] dir_b [4] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h1234_5678};

  initial begin
    logic [OW-1:0] a, b;
    int            gap;
    iRst   = 1'b1;
    iStart = 1'b0;
    iA     = '0;
    iB     = '0;
    repeat (3) @(posedge iClk);
    #1;
    check("reset_outputs", 64'({oDiff, oBorrow, oOverflow, oZero, oBusy, oDone}), 64'd0);

    // Start on the very first edge after reset release.
    iRst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_op(dir_a[i], dir_b[i]);
      wait_done($sformatf("directed%0d", i), 1'b0);
      repeat (2) @(posedge iClk);
      #1;
      check_idle_outputs($sformatf("directed%0d", i), last_exp);
    end

    // Start request with new operands during the second RUN cycle is ignored.
    start_op(32'hDEAD_BEEF, 32'h0BAD_F00D);
    wait_done("ignored_start", 1'b1);
    repeat (2) @(posedge iClk);
    #1;
    check_idle_outputs("ignored_start", last_exp);

    // Reset during the second RUN cycle aborts the operation.
    start_op(32'h0000_0009, 32'h0000_0004);
    @(posedge iClk); #1;
    iRst = 1'b1;
    @(posedge iClk); #1;
    check("midrun_reset_outputs", 64'({oDiff, oBorrow, oOverflow, oZero, oBusy, oDone}), 64'd0);
    void'(sb_q.pop_back());
    iRst = 1'b0;
    start_op(32'h0000_0100, 32'h0000_0001);
    wait_done("after_reset", 1'b0);

    // Back-to-back: new start accepted during the DONE cycle.
    start_op(32'h0000_0040, 32'h0000_0002);
    wait_done("b2b_first", 1'b0);
    start_op(32'h0000_0010, 32'h0000_0020);
    wait_done("b2b_second", 1'b0);
    check("b2b_second_diff", 64'({oDiff, oBorrow}), 64'({32'hFFFF_FFF0, 1'b1}));

    // Randomized operations with random spacing.
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: b = a;
        1: begin a[OW-1] = 1'b1; b[OW-1] = 1'b0; end
        2: begin a[OW-1] = 1'b0; b[OW-1] = 1'b1; end
        default: ;
      endcase
      start_op(a, b);
      wait_done($sformatf("random%0d", i), 1'b0);
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        repeat (gap) @(posedge iClk);
        #1;
        check_idle_outputs($sformatf("random%0d", i), last_exp);
      end
    end

    repeat (3) @(posedge iClk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
